// File: rtl/adder_operand_recover_serial.sv
// Bit-serial operand recovery for an adder: operand = sum - addend - cin, LSB first,
// with an error flag when no WIDTH-bit operand can produce the given sum.
module adder_operand_recover_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   sum,
  input  logic [WIDTH-1:0] addend,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] operand,
  output logic             err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic [WIDTH:0]   add_q, add_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic             err_q, err_d;

  logic d_bit;
  logic borrow_next;

  // Operand registers shift right each RUN cycle, so the current bit is always at index 0.
  assign d_bit       = sum_q[0] ^ add_q[0] ^ borrow_q;
  assign borrow_next = (~sum_q[0] & (add_q[0] | borrow_q)) | (add_q[0] & borrow_q);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    add_d     = add_q;
    borrow_d  = borrow_q;
    res_d     = res_q;
    operand_d = operand_q;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sum_d    = sum;
          add_d    = {1'b0, addend};
          borrow_d = cin;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        res_d    = {d_bit, res_q[WIDTH-1:1]};
        sum_d    = sum_q >> 1;
        add_d    = add_q >> 1;
        borrow_d = borrow_next;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH)) begin
          // Last cycle works on the extra MSB; res_q already holds d[WIDTH-1:0].
          operand_d = res_q;
          err_d     = d_bit | borrow_next;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sum_q     <= '0;
      add_q     <= '0;
      borrow_q  <= 1'b0;
      res_q     <= '0;
      operand_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      add_q     <= add_d;
      borrow_q  <= borrow_d;
      res_q     <= res_d;
      operand_q <= operand_d;
      err_q     <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign operand   = operand_q;
  assign err       = err_q;

endmodule

// File: tb/tb_adder_operand_recover_serial.sv
// Self-checking bench for adder_operand_recover_serial (WIDTH=4): vector table,
// scoreboard queue, back-pressure, mid-run reset and exhaustive sweep.
module tb_adder_operand_recover_serial;

  localparam int W = 4;

  typedef struct {
    logic [W:0]   sum;
    logic [W-1:0] addend;
    logic         cin;
    logic [W-1:0] op;
    logic         err;
  } vec_t;

  typedef struct {
    logic [W-1:0] op;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W:0]   sum = '0;
  logic [W-1:0] addend = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] operand;
  logic         err;
  logic         busy;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t vecs[8];

  adder_operand_recover_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .addend    (addend),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .operand   (operand),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Present one request for a single accept edge and record its expected result.
  task automatic send(input logic [W:0] s, input logic [W-1:0] a, input logic c,
                      input logic [W-1:0] eop, input logic eerr);
    exp_t e;
    int   n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check("in_ready_timeout", 32'(in_ready), 1);
    sum      = s;
    addend   = a;
    cin      = c;
    in_valid = 1'b1;
    e.op     = eop;
    e.err    = eerr;
    sb.push_back(e);
    step();
    in_valid = 1'b0;
    // Scramble inputs after acceptance; the result must not depend on them.
    sum      = (W+1)'($urandom);
    addend   = W'($urandom);
    cin      = 1'($urandom);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic collect(input int stall);
    exp_t e;
    for (int i = 0; i < stall; i++) step();
    check("stall_out_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    if (sb.size() == 0) begin
      check("sb_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      check("operand", 32'(operand), 32'(e.op));
      check("err", 32'(err), 32'(e.err));
    end
    step();
    out_ready = 1'b0;
  endtask

  task automatic run_one(input logic [W:0] s, input logic [W-1:0] a, input logic c,
                         input logic [W-1:0] eop, input logic eerr, input int stall);
    int   n;
    exp_t e;
    send(s, a, c, eop, eerr);
    wait_valid(n);
    check("out_valid_timeout", 32'(out_valid), 1);
    if (out_valid) collect(stall);
    else if (sb.size() != 0) e = sb.pop_front();
  endtask

  initial begin
    int   n;
    exp_t e;

    vecs[0] = '{5'd22, 4'd9,  1'b1, 4'd12, 1'b0};
    vecs[1] = '{5'd3,  4'd7,  1'b0, 4'd12, 1'b1};
    vecs[2] = '{5'd31, 4'd0,  1'b0, 4'd15, 1'b1};
    vecs[3] = '{5'd0,  4'd0,  1'b0, 4'd0,  1'b0};
    vecs[4] = '{5'd0,  4'd0,  1'b1, 4'd15, 1'b1};
    vecs[5] = '{5'd16, 4'd15, 1'b1, 4'd0,  1'b0};
    vecs[6] = '{5'd31, 4'd15, 1'b1, 4'd15, 1'b0};
    vecs[7] = '{5'd16, 4'd0,  1'b0, 4'd0,  1'b1};

    // Reset state
    repeat (3) step();
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_operand", 32'(operand), 0);
    check("rst_err", 32'(err), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    step();

    // Latency: out_valid exactly WIDTH+1 cycles after the accept edge
    send(5'd22, 4'd9, 1'b1, 4'd12, 1'b0);
    check("run_busy", 32'(busy), 1);
    check("run_in_ready", 32'(in_ready), 0);
    wait_valid(n);
    check("latency", 32'(n), 5);
    collect(0);
    check("post_hs_out_valid", 32'(out_valid), 0);
    check("post_hs_operand_hold", 32'(operand), 12);

    // Vector table with random consumer stalls
    for (int i = 0; i < 8; i++)
      run_one(vecs[i].sum, vecs[i].addend, vecs[i].cin, vecs[i].op, vecs[i].err,
              int'($urandom_range(0, 3)));

    // Back-pressure in DONE with in_valid pulses that must be ignored
    send(5'd31, 4'd0, 1'b0, 4'd15, 1'b1);
    wait_valid(n);
    check("bp_latency", 32'(n), 5);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'(i % 2);
      sum      = 5'd1;
      addend   = 4'd1;
      step();
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_in_ready", 32'(in_ready), 0);
      check("bp_operand", 32'(operand), 15);
      check("bp_err", 32'(err), 1);
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    e = sb.pop_front();
    check("bp_hs_operand", 32'(operand), 32'(e.op));
    check("bp_hs_err", 32'(err), 32'(e.err));
    step();
    out_ready = 1'b0;
    check("bp_after_out_valid", 32'(out_valid), 0);
    check("bp_after_in_ready", 32'(in_ready), 1);
    check("bp_after_busy", 32'(busy), 0);
    check("bp_after_operand", 32'(operand), 15);
    check("bp_after_err", 32'(err), 1);
    in_valid = 1'b0;

    // Reset during the second RUN cycle drops the transaction
    send(5'd9, 4'd2, 1'b0, 4'd7, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    e = sb.pop_back();
    check("mid_rst_in_ready", 32'(in_ready), 1);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_operand", 32'(operand), 0);
    check("mid_rst_err", 32'(err), 0);
    check("mid_rst_busy", 32'(busy), 0);
    for (int i = 0; i < 8; i++) begin
      step();
      check("mid_rst_no_output", 32'(out_valid), 0);
    end
    run_one(5'd16, 4'd8, 1'b0, 4'd8, 1'b0, 0);

    // Exhaustive sweep: sum built from a known operand must recover it
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          run_one(5'(a + b + c), 4'(b), 1'(c), 4'(a), 1'b0, int'($urandom_range(0, 2)));

    check("sb_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
